// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver running entirely in the system clock domain.
// KB_Clock and Data are synchronised and the clock is glitch filtered.
// Full 11-bit frames are checked for start, odd parity and stop bits.
// E0 and F0 prefix bytes are folded into per-code extended/break flags.
// Decoded codes are buffered in a first-word-fall-through FIFO.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KB_Clock,
  input  logic       Data,
  input  logic       Rd_en,
  output logic [9:0] Rd_data,
  output logic       Empty,
  output logic       Full,
  output logic       Parity_error,
  output logic       Frame_error,
  output logic       Timeout_error,
  output logic       Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_CNT  = CW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic                   filt_clk;
  logic [FW-1:0]          filt_cnt;
  logic                   fe;

  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          tcnt;
  logic [9:0]             shift_reg;
  logic                   ext_flag;
  logic                   brk_flag;

  logic [7:0]             frame_byte;
  logic                   parity_ok;
  logic                   stop_ok;
  logic                   push_req;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   do_pop;
  logic                   do_push;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Falling edge of the filtered clock: the last of FILTER_LEN low samples
  // is being seen while the filtered level is still high.
  assign fe = filt_clk & ~clk_s & (filt_cnt == FILT_LAST);

  // Shift register holds data[7:0], parity, stop once all ten bits are in.
  assign frame_byte = shift_reg[7:0];
  assign parity_ok  = ^shift_reg[8:0];
  assign stop_ok    = shift_reg[9];
  assign push_req   = (state == CHECK) && stop_ok && parity_ok &&
                      (frame_byte != 8'hE0) && (frame_byte != 8'hF0);

  assign Empty   = (count == '0);
  assign Full    = (count == DEPTH_CNT);
  assign do_pop  = Rd_en & ~Empty;
  assign do_push = push_req & (~Full | do_pop);
  assign Rd_data = mem[rd_ptr];

  // Bring the raw bus lines into the system clock domain, idling high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], KB_Clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], Data};
    end
  end

  // Filtered clock follows the synchronised clock only after a run of
  // FILTER_LEN consecutive samples that disagree with the current level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s != filt_clk) begin
      if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Frame receiver: start detect, bit shifting, timeout and frame checks,
  // with prefix flag tracking and registered one-cycle error pulses.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tcnt          <= '0;
      shift_reg     <= '0;
      ext_flag      <= 1'b0;
      brk_flag      <= 1'b0;
      Parity_error  <= 1'b0;
      Frame_error   <= 1'b0;
      Timeout_error <= 1'b0;
    end else begin
      Parity_error  <= 1'b0;
      Frame_error   <= 1'b0;
      Timeout_error <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (fe && !data_s) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          if (fe) begin
            tcnt      <= '0;
            shift_reg <= {data_s, shift_reg[9:1]};
            if (bit_cnt == 4'd9) begin
              state <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (tcnt == TIMEOUT_MAX) begin
            Timeout_error <= 1'b1;
            state         <= IDLE;
            tcnt          <= '0;
            ext_flag      <= 1'b0;
            brk_flag      <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          if (!stop_ok) begin
            Frame_error <= 1'b1;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
          end else if (!parity_ok) begin
            Parity_error <= 1'b1;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
          end else if (frame_byte == 8'hE0) begin
            ext_flag <= 1'b1;
          end else if (frame_byte == 8'hF0) begin
            brk_flag <= 1'b1;
          end else begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan-code FIFO: push and pop resolve on the same edge; a push into a
  // full FIFO with no pop is dropped and latches the sticky overflow flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {ext_flag, brk_flag, frame_byte};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_req && Full && !do_pop) begin
        Overflow <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: drives PS/2 frames bit by bit and
// compares the FIFO and error outputs against a frame-level reference model.
module tb_ps2_rx_fifo;

  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       Clock    = 1'b0;
  logic       Reset    = 1'b0;
  logic       KB_Clock = 1'b1;
  logic       Data     = 1'b1;
  logic       Rd_en    = 1'b0;
  logic [9:0] Rd_data;
  logic       Empty;
  logic       Full;
  logic       Parity_error;
  logic       Frame_error;
  logic       Timeout_error;
  logic       Overflow;

  int checks = 0;
  int passes = 0;

  // Reference model state: expected FIFO contents and prefix/overflow flags
  logic [9:0] exp_q[$];
  bit         m_ext;
  bit         m_brk;
  bit         m_ovf;

  // Pulse monitors: cycles high and rising edges of each error output
  int p_hi = 0, p_rise = 0, f_hi = 0, f_rise = 0, t_hi = 0, t_rise = 0;
  logic p_prev = 1'b0, f_prev = 1'b0, t_prev = 1'b0;

  ps2_rx_fifo #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .KB_Clock(KB_Clock), .Data(Data), .Rd_en(Rd_en),
    .Rd_data(Rd_data), .Empty(Empty), .Full(Full), .Parity_error(Parity_error),
    .Frame_error(Frame_error), .Timeout_error(Timeout_error), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  // Count error pulse widths and occurrences away from the active edge
  always @(negedge Clock) begin
    if (Parity_error) p_hi++;
    if (Parity_error && !p_prev) p_rise++;
    if (Frame_error) f_hi++;
    if (Frame_error && !f_prev) f_rise++;
    if (Timeout_error) t_hi++;
    if (Timeout_error && !t_prev) t_rise++;
    p_prev = Parity_error;
    f_prev = Frame_error;
    t_prev = Timeout_error;
  end

  // Frame-level model: returns 0 ok, 1 parity error, 2 frame error
  function automatic int model_frame(input logic [7:0] b, input logic bad_par,
                                     input logic stop_bit);
    if (!stop_bit) begin
      m_ext = 0; m_brk = 0; return 2;
    end
    if (bad_par) begin
      m_ext = 0; m_brk = 0; return 1;
    end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clock) Data = b;
    repeat (HALF) @(negedge Clock);
    KB_Clock = 1'b0;
    repeat (HALF) @(negedge Clock);
    KB_Clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop_bit);
    repeat (4) @(negedge Clock);
  endtask

  task automatic pop_one();
    @(negedge Clock) Rd_en = 1'b1;
    @(negedge Clock) Rd_en = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", Empty); else passes++;
    checks++; if (Full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", Full); else passes++;
    checks++; if (Rd_data !== 10'h000) $display("[TB] FAIL reset_rd_data: got %h expected 000", Rd_data); else passes++;
    checks++; if ({Overflow, Parity_error, Frame_error, Timeout_error} !== 4'b0)
      $display("[TB] FAIL reset_flags: got %b expected 0000",
               {Overflow, Parity_error, Frame_error, Timeout_error}); else passes++;
    Reset = 1'b1;
    model_reset();
    repeat (5) @(negedge Clock);
  endtask

  task automatic test_single_latency();
    logic [7:0] b = 8'h1C;
    int r;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b);
    @(negedge Clock) Data = 1'b1;
    repeat (HALF) @(negedge Clock);
    KB_Clock = 1'b0;
    repeat (SYNC + FILT) @(negedge Clock);
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL latency_early: got Empty=%b expected 1", Empty); else passes++;
    @(negedge Clock);
    r = model_frame(b, 1'b0, 1'b1);
    checks++; if (Empty !== 1'b0) $display("[TB] FAIL latency_on_time: got Empty=%b expected 0", Empty); else passes++;
    checks++; if (Rd_data !== exp_q[0]) $display("[TB] FAIL single_data: got %h expected %h", Rd_data, exp_q[0]); else passes++;
    repeat (HALF - SYNC - FILT - 1) @(negedge Clock);
    KB_Clock = 1'b1;
    repeat (4) @(negedge Clock);
    pop_one();
    void'(exp_q.pop_front());
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL single_pop_empty: got %b expected 1", Empty); else passes++;
  endtask

  task automatic test_prefixes();
    logic [7:0] seqs [3][3];
    int lens [3];
    int r;
    seqs[0] = '{8'hF0, 8'h1C, 8'h00}; lens[0] = 2;
    seqs[1] = '{8'hE0, 8'hF0, 8'h75}; lens[1] = 3;
    seqs[2] = '{8'hE0, 8'h74, 8'h00}; lens[2] = 2;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < lens[s]; k++) begin
        send_frame(seqs[s][k], 1'b0, 1'b1);
        r = model_frame(seqs[s][k], 1'b0, 1'b1);
      end
      checks++; if (Empty !== 1'b0 || exp_q.size() != 1)
        $display("[TB] FAIL prefix_count_%0d: got Empty=%b expected one entry", s, Empty); else passes++;
      checks++; if (Rd_data !== exp_q[0])
        $display("[TB] FAIL prefix_data_%0d: got %h expected %h", s, Rd_data, exp_q[0]); else passes++;
      pop_one();
      void'(exp_q.pop_front());
      checks++; if (Empty !== 1'b1) $display("[TB] FAIL prefix_single_%0d: got Empty=%b expected 1", s, Empty); else passes++;
    end
  endtask

  task automatic test_errors();
    int ph = p_hi, pr = p_rise, fh = f_hi, fr = f_rise, r;
    send_frame(8'h1C, 1'b1, 1'b1);
    r = model_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (p_hi - ph != 1 || p_rise - pr != 1)
      $display("[TB] FAIL parity_pulse: got %0d cycles/%0d pulses expected 1/1", p_hi - ph, p_rise - pr); else passes++;
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL parity_no_push: got Empty=%b expected 1", Empty); else passes++;
    send_frame(8'h2A, 1'b0, 1'b0);
    r = model_frame(8'h2A, 1'b0, 1'b0);
    checks++; if (f_hi - fh != 1 || f_rise - fr != 1)
      $display("[TB] FAIL frame_pulse: got %0d cycles/%0d pulses expected 1/1", f_hi - fh, f_rise - fr); else passes++;
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL frame_no_push: got Empty=%b expected 1", Empty); else passes++;
  endtask

  task automatic test_timeout();
    int th = t_hi, tr = t_rise, r;
    send_frame(8'hE0, 1'b0, 1'b1);
    r = model_frame(8'hE0, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    repeat (TO + 30) @(negedge Clock);
    m_ext = 0; m_brk = 0;
    checks++; if (t_hi - th != 1 || t_rise - tr != 1)
      $display("[TB] FAIL timeout_pulse: got %0d cycles/%0d pulses expected 1/1", t_hi - th, t_rise - tr); else passes++;
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL timeout_no_push: got Empty=%b expected 1", Empty); else passes++;
    send_frame(8'h1C, 1'b0, 1'b1);
    r = model_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (Empty !== 1'b0 || Rd_data !== 10'h01C)
      $display("[TB] FAIL timeout_recover: got Empty=%b data=%h expected 0/01c", Empty, Rd_data); else passes++;
    pop_one();
    void'(exp_q.pop_front());
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
    int r;
    for (int i = 0; i < 5; i++) begin
      send_frame(codes[i], 1'b0, 1'b1);
      r = model_frame(codes[i], 1'b0, 1'b1);
    end
    checks++; if (Full !== 1'b1) $display("[TB] FAIL ovf_full: got %b expected 1", Full); else passes++;
    checks++; if (Overflow !== m_ovf) $display("[TB] FAIL ovf_flag: got %b expected %b", Overflow, m_ovf); else passes++;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (Empty !== 1'b0 || Rd_data !== exp_q[0])
        $display("[TB] FAIL ovf_drain_%0d: got Empty=%b data=%h expected 0/%h", i, Empty, Rd_data, exp_q[0]); else passes++;
      pop_one();
      void'(exp_q.pop_front());
    end
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL ovf_empty: got %b expected 1", Empty); else passes++;
    checks++; if (Overflow !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", Overflow); else passes++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      logic bad_par, stop_bit;
      int sel, kind, ph, fh;
      sel = $urandom_range(0, 9);
      if (sel < 2) b = 8'hE0;
      else if (sel == 2) b = 8'hF0;
      else begin
        b = 8'($urandom);
        if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01;
      end
      sel = $urandom_range(0, 9);
      bad_par  = (sel == 0);
      stop_bit = (sel != 1);
      ph = p_hi; fh = f_hi;
      send_frame(b, bad_par, stop_bit);
      kind = model_frame(b, bad_par, stop_bit);
      checks++; if ((p_hi - ph) != int'(kind == 1) || (f_hi - fh) != int'(kind == 2))
        $display("[TB] FAIL rand_err_%0d: got par=%0d frm=%0d expected kind %0d", n, p_hi - ph, f_hi - fh, kind); else passes++;
      checks++; if (Empty !== (exp_q.size() == 0) || Overflow !== m_ovf)
        $display("[TB] FAIL rand_state_%0d: got Empty=%b Ovf=%b expected %b/%b", n, Empty, Overflow, exp_q.size() == 0, m_ovf); else passes++;
      if (exp_q.size() != 0) begin
        checks++; if (Rd_data !== exp_q[0])
          $display("[TB] FAIL rand_head_%0d: got %h expected %h", n, Rd_data, exp_q[0]); else passes++;
        if ($urandom_range(0, 1) == 1) begin
          pop_one();
          void'(exp_q.pop_front());
        end
      end
    end
    while (exp_q.size() != 0) begin
      checks++; if (Empty !== 1'b0 || Rd_data !== exp_q[0])
        $display("[TB] FAIL rand_drain: got Empty=%b data=%h expected 0/%h", Empty, Rd_data, exp_q[0]); else passes++;
      pop_one();
      void'(exp_q.pop_front());
    end
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL rand_final_empty: got %b expected 1", Empty); else passes++;
  endtask

  task automatic test_reset_glitch();
    int ph, fh, th, r;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge Clock) Reset = 1'b0;
    #1;
    model_reset();
    checks++; if (Empty !== 1'b1 || Overflow !== 1'b0)
      $display("[TB] FAIL async_reset: got Empty=%b Ovf=%b expected 1/0", Empty, Overflow); else passes++;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    repeat (4) @(negedge Clock);
    ph = p_hi; fh = f_hi; th = t_hi;
    KB_Clock = 1'b0;
    repeat (2) @(negedge Clock);
    KB_Clock = 1'b1;
    repeat (TO + 30) @(negedge Clock);
    checks++; if (p_hi != ph || f_hi != fh || t_hi != th || Empty !== 1'b1)
      $display("[TB] FAIL glitch_ignored: got errs=%0d Empty=%b expected 0/1", (p_hi - ph) + (f_hi - fh) + (t_hi - th), Empty); else passes++;
    send_frame(8'h29, 1'b0, 1'b1);
    r = model_frame(8'h29, 1'b0, 1'b1);
    checks++; if (Empty !== 1'b0 || Rd_data !== exp_q[0])
      $display("[TB] FAIL post_reset_frame: got Empty=%b data=%h expected 0/%h", Empty, Rd_data, exp_q[0]); else passes++;
    checks++; if (Overflow !== 1'b0) $display("[TB] FAIL post_reset_ovf: got %b expected 0", Overflow); else passes++;
    pop_one();
    void'(exp_q.pop_front());
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL post_reset_pop: got %b expected 1", Empty); else passes++;
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_single_latency();
    test_prefixes();
    test_errors();
    test_timeout();
    test_overflow();
    test_random();
    test_reset_glitch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
